// File: rtl/fetch_if.sv
// fetch_if: fetch-stage bus bundle (instruction memory port, redirect input, decode valid/ready output)
//   master (fetch_unit): drives imem_addr and out_*; samples imem_inst, redirect_*, out_ready
//   slave  (memory/execute/decode side): the mirror of master
interface fetch_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_inst;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_target;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_pc;
  logic [ADDR_W-1:0] out_pc_plus4;
  modport master (
    output imem_addr, out_valid, out_inst, out_pc, out_pc_plus4,
    input  imem_inst, redirect_valid, redirect_target, out_ready
  );
  modport slave (
    input  imem_addr, out_valid, out_inst, out_pc, out_pc_plus4,
    output imem_inst, redirect_valid, redirect_target, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: RISC-V fetch stage - owns the PC, queues fetched {inst, pc} pairs and hands them to decode
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : fetch_if.master - imem_addr/imem_inst, redirect_valid/redirect_target,
//           out_valid/out_ready/out_inst/out_pc/out_pc_plus4
module fetch_unit #(
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input logic      clk,
  input logic      rst_n,
  fetch_if.master  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_inst [DEPTH];
  logic [ADDR_W-1:0] r_epc  [DEPTH];
  logic [PW-1:0]     r_wr;
  logic [PW-1:0]     r_rd;
  logic [CW-1:0]     r_count;
  logic              w_pop;
  logic              w_push;
  assign w_pop  = (r_count != '0) & bus.out_ready;
  // a full queue still accepts a word when the head leaves in the same cycle
  assign w_push = !bus.redirect_valid & ((r_count < CW'(DEPTH)) | w_pop);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC & ~ADDR_W'(3);
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_inst[i] <= '0;
        r_epc[i]  <= '0;
      end
    end else begin
      if (w_push) begin
        r_inst[r_wr] <= bus.imem_inst;
        r_epc[r_wr]  <= r_pc;
        r_wr         <= r_wr + 1'b1;
        r_pc         <= r_pc + ADDR_W'(4);
      end
      // redirect flushes everything still queued; a same-cycle pop is already consumed
      if (bus.redirect_valid) begin
        r_pc    <= bus.redirect_target & ~ADDR_W'(3);
        r_rd    <= r_wr;
        r_count <= '0;
      end else begin
        r_rd    <= w_pop ? r_rd + 1'b1 : r_rd;
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end
  assign bus.imem_addr    = r_pc;
  assign bus.out_valid    = r_count != '0;
  assign bus.out_inst     = r_inst[r_rd];
  assign bus.out_pc       = r_epc[r_rd];
  assign bus.out_pc_plus4 = r_epc[r_rd] + ADDR_W'(4);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit (ADDR_W=10, RESET_PC=0, DEPTH=2)
module tb_fetch_unit;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   n_pop;
  int   pop_mark;
  fetch_if #(.ADDR_W(10)) bus ();
  fetch_unit #(.ADDR_W(10), .RESET_PC(10'h000), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  assign bus.imem_inst = 32'hA5A50000 | {22'd0, bus.imem_addr};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.out_valid && bus.out_ready) n_pop <= n_pop + 1;
  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      assert (dut.r_count <= 2) else begin
        bad++;
        $error("FAIL count_bound observed=%0d expected<=2", dut.r_count);
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic head(input string tag, input logic [9:0] pc);
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, "_pc"}, {22'd0, bus.out_pc}, {22'd0, pc});
    chk({tag, "_inst"}, bus.out_inst, 32'hA5A50000 | {22'd0, pc});
    chk({tag, "_pc4"}, {22'd0, bus.out_pc_plus4}, {22'd0, pc + 10'd4});
  endtask
  initial begin
    total = 0;
    bad = 0;
    n_pop = 0;
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = '0;
    tick;
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_inst", bus.out_inst, 32'd0);
    chk("rst_pc", {22'd0, bus.out_pc}, 32'd0);
    chk("rst_addr", {22'd0, bus.imem_addr}, 32'd0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      head("stream", 10'(4 * i));
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 10'h03B;
    tick;
    bus.redirect_valid = 1'b0;
    chk("redir_bubble", {31'd0, bus.out_valid}, 32'd0);
    chk("redir_addr", {22'd0, bus.imem_addr}, 32'h038);
    tick;
    head("redir_t0", 10'h038);
    tick;
    head("redir_t1", 10'h03C);
    bus.out_ready = 1'b0;
    tick;
    head("pre_reset", 10'h03C);
    chk("pre_reset_addr", {22'd0, bus.imem_addr}, 32'h044);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("async_pc", {22'd0, bus.out_pc}, 32'd0);
    chk("async_addr", {22'd0, bus.imem_addr}, 32'd0);
    tick;
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick;
      head("stall", 10'h000);
      chk("stall_addr", {22'd0, bus.imem_addr}, i == 1 ? 32'h004 : 32'h008);
    end
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick;
      head("release", 10'(4 * i));
    end
    bus.out_ready = 1'b0;
    tick;
    head("full", 10'h00C);
    chk("full_addr", {22'd0, bus.imem_addr}, 32'h014);
    chk("full_count", {29'd0, dut.r_count}, 32'd2);
    pop_mark = n_pop;
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 10'h100;
    tick;
    bus.redirect_valid = 1'b0;
    chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_count", {29'd0, dut.r_count}, 32'd0);
    chk("flush_pops", n_pop - pop_mark, 32'd1);
    chk("flush_addr", {22'd0, bus.imem_addr}, 32'h100);
    tick;
    head("flush_head", 10'h100);
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 10'h3F8;
    tick;
    bus.redirect_valid = 1'b0;
    chk("wrap_bubble", {31'd0, bus.out_valid}, 32'd0);
    tick;
    head("wrap0", 10'h3F8);
    tick;
    head("wrap1", 10'h3FC);
    chk("wrap1_pc4", {22'd0, bus.out_pc_plus4}, 32'h000);
    tick;
    head("wrap2", 10'h000);
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 10'h200;
    tick;
    bus.redirect_target = 10'h086;
    tick;
    bus.redirect_valid = 1'b0;
    chk("b2b_bubble", {31'd0, bus.out_valid}, 32'd0);
    chk("b2b_addr", {22'd0, bus.imem_addr}, 32'h084);
    tick;
    head("b2b_head", 10'h084);
    tick;
    head("b2b_next", 10'h088);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the single-cycle/pipelined RISC-V core. It owns the program counter and drives the byte address into the combinational instruction memory. It captures the returned 32-bit word into a small FIFO and hands {instruction, PC} to decode over a valid/ready handshake. It also accepts taken-branch/jump redirects from execute and flushes wrong-path instructions.

## Interface
- ADDR_W, 10, byte-address width; matches the instruction memory address port.
- RESET_PC, 0, PC value loaded on reset; bits [1:0] must be 0.
- DEPTH, 2, fetch queue entries; power of two, 2..8.

- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- imem_addr  output  ADDR_W  byte address to instruction memory; equals the PC register directly, with no logic after the flop.
- imem_inst  input  32  instruction word; combinationally valid in the same cycle as imem_addr.
- redirect_valid  input  1  single-cycle pulse: branch/jump taken.
- redirect_target  input  ADDR_W  new PC; bits [1:0] are ignored and forced to 0.
- out_valid  output  1  queue head holds a valid instruction.
- out_ready  input  1  decode accepts the head this cycle.
- out_inst  output  32  instruction at the queue head.
- out_pc  output  ADDR_W  PC of out_inst.
- out_pc_plus4  output  ADDR_W  out_pc + 4, modulo 2^ADDR_W; decode uses it for jal/jalr link.

## Operation
- State:
  - pc register (ADDR_W bits).
  - Circular queue of DEPTH entries {inst, pc}.
  - wr_ptr and rd_ptr, log2(DEPTH) bits, wrapping.
  - count, log2(DEPTH)+1 bits.
- pop = out_valid & out_ready.
- push = !redirect_valid & (count < DEPTH | pop).
- A full queue with a simultaneous pop still pushes in the same cycle.
- On push: the entry at wr_ptr gets {imem_inst, pc}; wr_ptr advances; pc <= pc + 4, wrapping modulo 2^ADDR_W (0x3FC -> 0x000).
- No push: pc holds, and imem_addr stays stable across the stall.
- On pop: rd_ptr advances.
- count: +1 on push only; -1 on pop only; unchanged when both or neither occur.
- Redirect has priority over push:
  - rd_ptr <= wr_ptr and count <= 0, flushing every queued entry.
  - pc <= {redirect_target[ADDR_W-1:2], 2'b00}.
  - No push occurs that cycle.
  - A pop in the same cycle still completes: decode has consumed that head, then the rest is flushed.
- Output rules:
  - out_valid = (count != 0).
  - out_inst and out_pc come from the entry at rd_ptr.
  - out_pc_plus4 = out_pc + 4, truncated to ADDR_W.
- Handshake rule: while out_valid=1 and out_ready=0, out_inst, out_pc and out_pc_plus4 must not change unless redirect_valid=1.
- Overflow and underflow are impossible by construction. The bench asserts count <= DEPTH every cycle.

## Timing
- Reset (async assert, synchronous release on first clk edge after rst_n rises):
  - pc = RESET_PC.
  - count, rd_ptr, wr_ptr = 0.
  - out_valid = 0.
  - All queue entries = 0, so out_inst = 0 and out_pc = 0.
- Reset mid-operation discards all queued entries and in-flight redirects immediately (asynchronously).
- First instruction: at the first edge after reset release, the word at RESET_PC is pushed; out_valid = 1 after that edge.
- Throughput: one instruction per cycle with out_ready held high.
- Latency is 1 cycle from imem_addr to out_valid.
- Redirect latency:
  - Redirect sampled at edge E: pc = target after E, and out_valid = 0 for one cycle.
  - The target instruction is pushed at E+1 and appears at the head after E+1.
  - This gives exactly one bubble.
- Back-to-back redirects: each one overrides the previous one; the last target wins.
- Stall: with out_ready=0, the queue fills in DEPTH cycles, then pc freezes.
  - When out_ready rises, the pop and the next push occur in the same cycle.

## Test plan
- Test memory model: imem_inst = 32'hA5A50000 | imem_addr.
- Reset/stream:
  - Stimulus: release rst_n, out_ready=1.
  - Required: out_pc = 0x000, 0x004, 0x008... on consecutive cycles; out_inst = 0xA5A50000, 0xA5A50004...; out_pc_plus4 = out_pc + 4.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles, then 1.
  - Required: the head holds 0x000; pc freezes at 0x008 (DEPTH=2); after release, 0x000, 0x004, 0x008 stream with no duplicates and no gaps.
- Redirect:
  - Stimulus: while streaming, pulse redirect_valid with target 0x03B when out_pc = 0x00C.
  - Required: next cycle out_valid=0; the cycle after, out_pc = 0x038 and out_inst = 0xA5A50038; no instruction at 0x010 ever appears.
- Redirect while full and stalled:
  - Stimulus: out_ready=0, queue full, redirect to 0x100 with simultaneous out_ready=1.
  - Required: exactly one pop of the old head; count returns to 0; the next head is 0x100.
- Wrap-around:
  - Stimulus: redirect to 0x3F8.
  - Required: out_pc sequence is 0x3F8, 0x3FC, 0x000; out_pc_plus4 at 0x3FC = 0x000.
- Async reset mid-stream:
  - Stimulus: drop rst_n between edges with 2 entries queued.
  - Required: out_valid falls immediately; after release, fetch restarts at RESET_PC.
